// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MEM stage and a word-organised
// data memory. Handles one request at a time, performs read-modify-write for
// sub-word stores, extends sub-word loads and flags misaligned requests.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_*             request handshake and payload (sampled on accept)
//   resp_*            one-cycle completion pulse, error flag, load result
//   dm_*              word-aligned data memory interface (combinational read)
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  dm_read_en,
  output logic                  dm_write_en,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [DATA_WIDTH-1:0] dm_write_data,
  input  logic [DATA_WIDTH-1:0] dm_read_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] merged_q, merged_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            offset;
  logic [4:0]            lane_lsb;
  logic                  misaligned;
  logic [BYTE_W-1:0]     ld_byte;
  logic [HALF_W-1:0]     ld_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merged_word;

  assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign offset    = req_addr[1:0];
  assign lane_lsb  = {offset, 3'b000};

  // Alignment check; reserved size is always rejected
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Load lane extraction and sign/zero extension
  always_comb begin
    ld_byte = dm_read_data[lane_lsb +: BYTE_W];
    ld_half = req_addr[1] ? dm_read_data[2*HALF_W-1:HALF_W] : dm_read_data[HALF_W-1:0];
    case (req_size)
      SZ_BYTE: load_ext = req_unsigned ? {{(DATA_WIDTH-BYTE_W){1'b0}}, ld_byte}
                                       : {{(DATA_WIDTH-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
      SZ_HALF: load_ext = req_unsigned ? {{(DATA_WIDTH-HALF_W){1'b0}}, ld_half}
                                       : {{(DATA_WIDTH-HALF_W){ld_half[HALF_W-1]}}, ld_half};
      default: load_ext = dm_read_data;
    endcase
  end

  // Store lane merge into the word read from memory
  always_comb begin
    merged_word = dm_read_data;
    if (req_size == SZ_BYTE) begin
      merged_word[lane_lsb +: BYTE_W] = req_wdata[BYTE_W-1:0];
    end else if (req_addr[1]) begin
      merged_word[2*HALF_W-1:HALF_W] = req_wdata[HALF_W-1:0];
    end else begin
      merged_word[HALF_W-1:0] = req_wdata[HALF_W-1:0];
    end
  end

  // Next-state and memory-side outputs
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    merged_d      = merged_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    req_ready     = 1'b0;
    dm_read_en    = 1'b0;
    dm_write_en   = 1'b0;
    dm_addr       = '0;
    dm_write_data = '0;

    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid && rst_n) begin
          resp_valid_d = 1'b1;
          if (misaligned) begin
            resp_err_d = 1'b1;
          end else if (!req_write) begin
            dm_read_en   = 1'b1;
            dm_addr      = word_addr;
            resp_rdata_d = load_ext;
          end else if (req_size == SZ_WORD) begin
            dm_write_en   = 1'b1;
            dm_addr       = word_addr;
            dm_write_data = req_wdata;
          end else begin
            // Sub-word store: read now, write the merged word next cycle
            dm_read_en   = 1'b1;
            dm_addr      = word_addr;
            addr_d       = word_addr;
            merged_d     = merged_word;
            resp_valid_d = 1'b0;
            state_d      = RMW_WR;
          end
        end
      end
      RMW_WR: begin
        // Gating with rst_n drops a pending write when reset hits this cycle
        dm_write_en   = rst_n;
        dm_addr       = addr_q;
        dm_write_data = merged_q;
        resp_valid_d  = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      merged_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      merged_q     <= merged_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store unit between the MEM pipeline stage and the word-organised data memory.
- Accepts one load or store request at a time. Generates word-aligned memory reads and writes.
- Performs read-modify-write for byte and halfword stores. Extracts and sign- or zero-extends byte and halfword loads.
- Flags misaligned accesses instead of touching memory.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on both sides.
- DATA_WIDTH, 32, data word width. Only 32 is supported.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- req_unsigned  input  1  zero-extend loads when 1
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  misaligned or reserved size; qualified by resp_valid
- resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors
- dm_read_en  output  1  data memory read enable
- dm_write_en  output  1  data memory write enable
- dm_addr  output  ADDR_WIDTH  word-aligned byte address to memory
- dm_write_data  output  DATA_WIDTH  word to write
- dm_read_data  input  DATA_WIDTH  combinational read data from memory

Behaviour:
- Memory model:
  - Read data is combinational from dm_addr while dm_read_en=1.
  - A write commits on the posedge where dm_write_en=1.
- Addressing and byte order:
  - dm_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}.
  - Little-endian lanes: byte offset k occupies bits [8k+7:8k]. A halfword at offset 2 occupies [31:16].
- Reset:
  - While rst_n=0 at a posedge: state←IDLE; resp_valid, resp_err and resp_rdata←0; captured registers cleared.
  - dm_write_en is gated with rst_n, so no memory write occurs in any reset cycle. A store pending in RMW_WR is dropped.
- Handshake:
  - Accept occurs when req_valid && req_ready.
  - req_ready=1 only in IDLE with rst_n=1.
  - All req_* inputs are sampled only at accept.
  - resp_valid has no back-pressure.
- Alignment:
  - Halfword requires addr[0]=0. Word requires addr[1:0]=00. size 11 is always an error.
  - On error: no dm_read_en or dm_write_en; resp_valid=1 with resp_err=1 and resp_rdata=0 on the next cycle; state stays IDLE.
- FSM states: IDLE, RMW_WR.
- IDLE, aligned load accepted:
  - dm_read_en=1 combinationally in the accept cycle.
  - At the posedge, resp_rdata ← extract/extend(dm_read_data, offset, size, unsigned), resp_valid←1.
  - Latency 1 cycle; throughput 1 per cycle.
- IDLE, word store accepted:
  - dm_write_en=1 and dm_write_data=req_wdata in the accept cycle.
  - resp_valid=1 and resp_rdata=0 the next cycle. Latency 1 cycle.
- IDLE, byte or halfword store accepted:
  - dm_read_en=1 in the accept cycle.
  - At the posedge, register merged = dm_read_data with the target lane(s) replaced by req_wdata[7:0] or [15:0]. Also register the word address. Go to RMW_WR.
- RMW_WR:
  - req_ready=0, dm_write_en=1, dm_addr = registered address, dm_write_data = merged.
  - Next cycle: IDLE, with resp_valid=1 on that cycle.
  - Latency 2 cycles; throughput one every 2 cycles.
- Output defaults: dm_* outputs are 0 when unused. resp_valid deasserts the cycle after its pulse unless a new completion occurs.
- Back-to-back requests:
  - A load accepted on the cycle after a store's final write sees the new data, because the write committed at the prior posedge.
  - A load in the same cycle as RMW_WR is impossible, since req_ready=0.

Test Plan:
- Word round trip: store 0xDEADBEEF to addr 0x10, then load word 0x10 → resp_rdata=0xDEADBEEF one cycle after accept, resp_err=0.
- Byte store RMW: memory[0x10]=0x11223344; store byte 0xAB to 0x12 → 2-cycle busy with req_ready=0 in RMW_WR; word at 0x10 becomes 0x11AB3344.
- Load extension: word 0x80FF7F01 at 0x20.
  - Load byte signed at 0x22 → 0xFFFFFFFF.
  - Load byte unsigned at 0x22 → 0x000000FF.
  - Load half signed at 0x22 → 0xFFFF80FF.
  - Load half unsigned at 0x20 → 0x00007F01.
- Misalignment: load word 0x21, store half 0x23, size 11 → each gives resp_err=1 and resp_rdata=0, with no dm_read_en or dm_write_en pulses, and memory unchanged.
- Reset mid-RMW: assert rst_n=0 in the RMW_WR cycle of a byte store to 0x30 → dm_write_en stays 0, word 0x30 unchanged, req_ready=1 after reset release, resp_valid never pulses.
- Throughput: 4 consecutive word loads on req_valid=1 → 4 accepts in 4 cycles, 4 consecutive resp_valid pulses with correct data.
